// File: rtl/input_pkg.sv
// Shared constants for the switch input conditioner.
package input_pkg;

  localparam int CLK_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS = 10;

  // Default stability window: DEBOUNCE_MS expressed in clk cycles.
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

  localparam logic MODE_LEVEL  = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  // Counter width that holds 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One switch channel: synchronisers, stability counter, debounced level,
// push-on/push-off toggle and one-cycle edge pulses.
module debounce_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  input  logic mode,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic             m1, m2;
  logic [CNT_W-1:0] cnt;
  logic             deb;
  logic             tog;
  logic             update;

  // The window completes when s2 has disagreed with deb for N edges in a row.
  assign update = (s2 != deb) && (cnt == CNT_MAX);

  // Two-flop synchronisers for the raw switch and mode levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      m1 <= 1'b0;
      m2 <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      m1 <= mode;
      m2 <= m1;
    end
  end

  // Stability counter: any agreement with deb restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (s2 == deb || update) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Debounced level, toggle state and registered edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb  <= 1'b0;
      tog  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      if (update) deb <= s2;
      tog  <= tog ^ (update & s2);
      rise <= update & s2;
      fall <= update & ~s2;
    end
  end

  // Mode only selects which registered state is visible; it never alters it.
  assign level = (m2 == MODE_TOGGLE) ? tog : deb;

endmodule

// File: rtl/input_conditioner.sv
// Three-channel switch conditioner feeding the gate stage's a/b/c inputs.
module input_conditioner
  import input_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [WIDTH-1:0] mode_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  // Derived from the window length; not meant to be overridden.
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  // Channels are fully independent; one conditioner per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .sw    (sw_in[i]),
      .mode  (mode_in[i]),
      .level (level_out[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with N = 4, WIDTH = 3.
module tb_input_conditioner;

  localparam int W = 3;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_in;
  logic [W-1:0] mode_in;
  logic [W-1:0] level_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  int checks = 0;
  int errors = 0;

  input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_in      (sw_in),
    .mode_in    (mode_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: history of inputs sampled at each edge (zero after reset,
  // matching cleared synchronisers).  The debounced level adopts a new value
  // once the last N synchronised samples all disagree with it.
  bit [W-1:0] sw_h [0:N+1];
  bit [W-1:0] md_h [0:1];
  bit [W-1:0] m_deb, m_tog, m_rise, m_fall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= N + 1; k++) sw_h[k] = '0;
      md_h[0] = '0;
      md_h[1] = '0;
      m_deb = '0; m_tog = '0; m_rise = '0; m_fall = '0;
    end else begin
      for (int c = 0; c < W; c++) begin
        bit all_differ;
        all_differ = 1'b1;
        for (int k = 1; k <= N; k++)
          if (sw_h[k][c] == m_deb[c]) all_differ = 1'b0;
        m_rise[c] = all_differ & sw_h[1][c];
        m_fall[c] = all_differ & ~sw_h[1][c];
        if (all_differ) m_deb[c] = sw_h[1][c];
        if (m_rise[c]) m_tog[c] = ~m_tog[c];
      end
      for (int k = N + 1; k > 0; k--) sw_h[k] = sw_h[k-1];
      sw_h[0] = sw_in;
      md_h[1] = md_h[0];
      md_h[0] = mode_in;
    end
  end

  function automatic logic [W-1:0] exp_level();
    logic [W-1:0] r;
    for (int c = 0; c < W; c++) r[c] = md_h[1][c] ? m_tog[c] : m_deb[c];
    return r;
  endfunction

  // Continuous comparison one time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    check("cyc_level", level_out, exp_level());
    check("cyc_rise", rise_pulse, m_rise);
    check("cyc_fall", fall_pulse, m_fall);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [W-1:0] sw, input logic [W-1:0] md);
    @(negedge clk);
    rst = 1'b1; sw_in = sw; mode_in = md;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int rcnt, fcnt;

  initial begin
    rst = 1'b1; sw_in = '0; mode_in = '0;
    tick(); tick();
    check("reset_level", level_out, 3'b000);
    check("reset_rise", rise_pulse, 3'b000);
    check("reset_fall", fall_pulse, 3'b000);
    @(negedge clk); rst = 1'b0;

    // Clean press on channel 0, level mode.
    @(negedge clk); sw_in = 3'b001;
    repeat (5) tick();
    check("press_lvl_e5", level_out, 3'b000);
    check("press_rise_e5", rise_pulse, 3'b000);
    tick();
    check("press_lvl_e6", level_out, 3'b001);
    check("press_rise_e6", rise_pulse, 3'b001);
    check("press_fall_e6", fall_pulse, 3'b000);
    tick();
    check("press_rise_e7", rise_pulse, 3'b000);
    check("press_fall_e7", fall_pulse, 3'b000);

    // Bounce on channel 1: 1,0,1,0 then hold 1.
    rcnt = 0; fcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); sw_in[1] = (i % 2 == 0);
      tick();
      rcnt += rise_pulse[1]; fcnt += fall_pulse[1];
    end
    @(negedge clk); sw_in[1] = 1'b1;
    repeat (5) begin
      tick();
      rcnt += rise_pulse[1]; fcnt += fall_pulse[1];
    end
    check("bounce_pulses", rcnt + fcnt, 0);
    check("bounce_lvl_e5", level_out[1], 1'b0);
    tick();
    check("bounce_lvl_e6", level_out[1], 1'b1);
    check("bounce_rise_e6", rise_pulse, 3'b010);

    // Simultaneous press on all channels.
    do_reset(3'b000, 3'b000);
    @(negedge clk); sw_in = 3'b111;
    repeat (5) tick();
    check("simul_lvl_e5", level_out, 3'b000);
    tick();
    check("simul_rise_e6", rise_pulse, 3'b111);
    check("simul_lvl_e6", level_out, 3'b111);
    tick();
    check("simul_rise_e7", rise_pulse, 3'b000);

    // Asynchronous reset mid-cycle with all switches held high.
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("async_rst_lvl", level_out, 3'b000);
    check("async_rst_rise", rise_pulse, 3'b000);
    check("async_rst_fall", fall_pulse, 3'b000);
    @(negedge clk); rst = 1'b0;
    repeat (5) tick();
    check("rel_lvl_e5", level_out, 3'b000);
    tick();
    check("rel_lvl_e6", level_out, 3'b111);
    check("rel_rise_e6", rise_pulse, 3'b111);

    // Toggle mode on channel 2: two press/release cycles.
    do_reset(3'b000, 3'b100);
    repeat (3) tick();
    rcnt = 0; fcnt = 0;
    for (int seg = 0; seg < 4; seg++) begin
      @(negedge clk); sw_in[2] = (seg % 2 == 0);
      repeat (10) begin
        tick();
        rcnt += rise_pulse[2]; fcnt += fall_pulse[2];
      end
      case (seg)
        0: check("tog_after_press1", level_out[2], 1'b1);
        1: check("tog_after_rel1", level_out[2], 1'b1);
        2: check("tog_after_press2", level_out[2], 1'b0);
        default: check("tog_after_rel2", level_out[2], 1'b0);
      endcase
    end
    check("tog_rise_cnt", rcnt, 2);
    check("tog_fall_cnt", fcnt, 2);

    // Reset in the middle of a qualification window.
    do_reset(3'b000, 3'b000);
    rcnt = 0;
    @(negedge clk); sw_in = 3'b001;
    repeat (3) begin tick(); rcnt += rise_pulse[0]; end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_no_pulse", rcnt, 0);
    repeat (5) begin tick(); rcnt += rise_pulse[0]; end
    check("midrst_lvl_e5", level_out[0], 1'b0);
    tick(); rcnt += rise_pulse[0];
    check("midrst_lvl_e6", level_out[0], 1'b1);
    repeat (3) begin tick(); rcnt += rise_pulse[0]; end
    check("midrst_rise_cnt", rcnt, 1);

    // Randomised traffic: mostly held levels with occasional flips and bursts,
    // random mode changes and rare asynchronous resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(0, 7) == 0) sw_in[c] = ~sw_in[c];
        if ($urandom_range(0, 63) == 0) mode_in[c] = ~mode_in[c];
      end
      if ($urandom_range(0, 399) == 0) begin
        #($urandom_range(1, 3)) rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Three-channel switch conditioner that sits directly upstream of the basic-gate logic stage and drives its `a`, `b`, `c` inputs from raw board switches. Each channel is synchronised into the `clk` domain, debounced by a stability counter, and optionally converted to a push-on/push-off toggle. Each channel also emits one-cycle rise and fall pulses, so later sequential stages can count events without re-detecting edges.

## Interface
- `WIDTH`, 3: number of independent channels; bit 0 drives `a`, bit 1 drives `b`, bit 2 drives `c`.
- `DEBOUNCE_CYCLES`, 1_000_000: stability window N in clock cycles (10 ms at 100 MHz). Must be ≥ 1.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)` (minimum 1): debounce counter width; derived, do not override.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `sw_in`  input  WIDTH  raw, asynchronous, possibly bouncing switch levels.
- `mode_in`  input  WIDTH  raw per-channel mode: 0 = level, 1 = toggle.
- `level_out`  output  WIDTH  conditioned level per channel; feeds the gate stage.
- `rise_pulse`  output  WIDTH  one-cycle pulse when a debounced level goes 0→1.
- `fall_pulse`  output  WIDTH  one-cycle pulse when a debounced level goes 1→0.

## Operation
- Each channel has a two-flop synchroniser on `sw_in` (`s1` → `s2`) and a separate two-flop synchroniser on `mode_in` (`m2`).
- Per-channel state: `s1`, `s2`, `cnt[CNT_W]`, `deb`, `tog`, `m1`, `m2`, `rise`, `fall`.
- Debounce rule, evaluated every edge:
  - If `s2 == deb`: `cnt <= 0`.
  - If `s2 != deb` and `cnt == N-1`: `deb <= s2`, `cnt <= 0`, and the "update" event fires.
  - If `s2 != deb` otherwise: `cnt <= cnt + 1`.
- Any bounce back to `deb` before the window completes clears `cnt`. The window then restarts from zero on the next mismatch.
- Pulses are registered and computed from the update event on the same edge:
  - `rise <= update & s2`.
  - `fall <= update & ~s2`.
  - Otherwise both are 0, so each pulse lasts exactly one cycle.
- Toggle register: `tog <= tog ^ (update & s2)`. Only debounced rising edges flip it.
- Output select: `level_out = m2 ? tog : deb`. This is a combinational mux of registered signals.
  - Switching mode does not alter `tog` or `deb`; it only changes which one is visible.
- Channels are fully independent. Simultaneous activity on several channels is processed in parallel with no interaction.

## Timing
- Reset (asynchronous assert) sets every register to 0. During and after reset, `level_out`, `rise_pulse` and `fall_pulse` are all 0.
- Latency: number as edge 1 the first edge that samples a new `sw_in` level into `s1`. If the level then holds steady:
  - `deb`, and `level_out` in level mode, change after edge N+2.
  - The matching pulse is high for exactly the cycle between edges N+2 and N+3.
  - In toggle mode, `tog` flips on the same edge N+2.
- Mode changes reach the output mux after 2 edges and take effect on the output immediately after that.
- Glitch rejection: a new level that holds for fewer than N consecutive `s2` samples produces no change and no pulse.
- Reset mid-count discards the partial count and the pending level. After release, a still-asserted switch is re-qualified over a full N+2 edges.
- A held input never produces repeated pulses. `cnt` stays 0 while `s2 == deb`.
- `cnt` never exceeds N-1, so it has no wrap-around.

## Structure
- Shared package `input_pkg`:
  - `CLK_HZ = 100_000_000`.
  - `DEBOUNCE_MS = 10`.
  - Derived default `DEBOUNCE_CYCLES`.
  - `localparam MODE_LEVEL = 1'b0`, `MODE_TOGGLE = 1'b1`.
- Sub-module `debounce_channel` holds one channel's synchronisers, counter, `deb`, `tog` and pulse logic. `input_conditioner` instantiates it WIDTH times in a generate loop.

## Test plan
All scenarios use N = 4 and WIDTH = 3.
- Reset: assert `rst` asynchronously mid-cycle with all `sw_in` = 1 → `level_out` = 000 and both pulse buses = 000 immediately. After release, `level_out` = 001…111 follows the switches only after 6 edges.
- Clean press, level mode: `sw_in[0]` 0→1 and held → `level_out[0]` = 1 after edge 6. `rise_pulse` = 001 for exactly one cycle, then `fall_pulse` = 000 throughout.
- Bounce: `sw_in[1]` toggles 1,0,1,0 on successive cycles, then holds at 1 → no pulse during the bouncing. `level_out[1]` rises 6 edges after the final transition.
- Toggle mode: `mode_in[2]` = 1, then press and release `sw_in[2]` twice, each level held 10 cycles → `level_out[2]` goes 0→1→0. There are two `rise_pulse[2]` and two `fall_pulse[2]` pulses, and `tog` flips only on the rises.
- Simultaneous events: all three switches 0→1 on the same edge with `mode_in` = 000 → `rise_pulse` = 111 in a single cycle, and `level_out` = 111 after edge 6.
- Reset mid-count: `sw_in[0]` = 1 held, `rst` pulsed at edge 4 → no pulse before reset. After release, `level_out[0]` = 1 after 6 further edges, with one `rise_pulse[0]`.
